cache_mem_arbiter: RTL and testbench

- Shares one memory port between two cache-side requesters: port 0 is the icache refill/evict port and port 1 is the dcache refill/evict port.
- Sits between the two cache controllers' cache_req/cache_resp interfaces and the single test memory port.
- Arbitrates requests round-robin and forwards the winner with zero latency.
- Records the winner's ID in an in-order queue so each memory response is routed back to the requester that issued it.

---
 rtl/cache_arb_pkg.sv | 25 ++
 rtl/cache_arb_id_queue.sv | 51 +++++
 rtl/cache_mem_arbiter.sv | 100 ++++++++++
 tb/tb_cache_mem_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Types shared by the cache-to-memory arbiter: requester IDs and 4-byte memory messages.
// Message layouts follow the vc mem-msg definitions used by the cache controllers.
package cache_arb_pkg;

   localparam int ARB_NUM_REQS = 2;

   typedef logic [$clog2(ARB_NUM_REQS)-1:0] arb_id_t;

   typedef struct packed {
      logic [2:0]  msg_type;
      logic [7:0]  opaque;
      logic [31:0] addr;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_req_4B_t;

   typedef struct packed {
      logic [2:0]  msg_type;
      logic [7:0]  opaque;
      logic [1:0]  test;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_resp_4B_t;

endpackage

// File: rtl/cache_arb_id_queue.sv
// In-order FIFO of requester IDs, one entry per in-flight memory request.
// Latency: push visible at head the cycle after; head/full/empty are registered-state decodes.
// Backpressure: push ignored while full, pop ignored while empty.
module cache_arb_id_queue
   import cache_arb_pkg::*;
#(
   parameter int p_depth = 4
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    push,
   input  arb_id_t push_id,
   input  logic    pop,
   output arb_id_t head,
   output logic    full,
   output logic    empty
);

   localparam int AW = $clog2(p_depth);

   arb_id_t       slots [p_depth];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(p_depth));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = slots[rd_ptr];

   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) slots[wr_ptr] <= push_id;
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin share of one memory port between icache (0) and dcache (1); CACHE_ARB_STATS_EN adds counters.
// Latency: zero-cycle request forwarding and response routing; grant pointer updates on each fire.
// Backpressure: requests stall when memory is not ready or the ID queue is full; responses stall on the owner's rdy.
module cache_mem_arbiter
   import cache_arb_pkg::*;
#(
   parameter int p_max_outstanding = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0_val,
   output logic         req0_rdy,
   input  mem_req_4B_t  req0_msg,
   output logic         resp0_val,
   input  logic         resp0_rdy,
   output mem_resp_4B_t resp0_msg,
   input  logic         req1_val,
   output logic         req1_rdy,
   input  mem_req_4B_t  req1_msg,
   output logic         resp1_val,
   input  logic         resp1_rdy,
   output mem_resp_4B_t resp1_msg,
   output logic         mem_req_val,
   input  logic         mem_req_rdy,
   output mem_req_4B_t  mem_req_msg,
   input  logic         mem_resp_val,
   output logic         mem_resp_rdy,
   input  mem_resp_4B_t mem_resp_msg
`ifdef CACHE_ARB_STATS_EN
   ,
   output logic [31:0]  grant_count0,
   output logic [31:0]  grant_count1,
   output logic [31:0]  conflict_count
`endif
);

   arb_id_t priority_ptr;
   arb_id_t winner;
   arb_id_t head_id;
   logic    q_full;
   logic    q_empty;
   logic    active;
   logic    req_fire;
   logic    resp_fire;

   assign active = ~reset;

   always_comb begin
      winner = arb_id_t'(0);
      if (req0_val && req1_val) winner = priority_ptr;
      else if (req1_val)        winner = arb_id_t'(1);
   end

   // Full blocks the grant outright so rdy never depends on the response side.
   assign mem_req_val = active & ~q_full & (req0_val | req1_val);
   assign mem_req_msg = (winner == arb_id_t'(1)) ? req1_msg : req0_msg;
   assign req0_rdy    = active & ~q_full & mem_req_rdy & (winner == arb_id_t'(0));
   assign req1_rdy    = active & ~q_full & mem_req_rdy & (winner == arb_id_t'(1));
   assign req_fire    = mem_req_val & mem_req_rdy;

   always_ff @(posedge clk) begin
      if (reset)         priority_ptr <= arb_id_t'(0);
      else if (req_fire) priority_ptr <= ~winner;
   end

   assign resp0_val    = active & ~q_empty & mem_resp_val & (head_id == arb_id_t'(0));
   assign resp1_val    = active & ~q_empty & mem_resp_val & (head_id == arb_id_t'(1));
   assign resp0_msg    = mem_resp_msg;
   assign resp1_msg    = mem_resp_msg;
   assign mem_resp_rdy = active & ~q_empty & ((head_id == arb_id_t'(1)) ? resp1_rdy : resp0_rdy);
   assign resp_fire    = mem_resp_val & mem_resp_rdy;

   cache_arb_id_queue #(
      .p_depth (p_max_outstanding)
   ) u_id_queue (
      .clk     (clk),
      .reset   (reset),
      .push    (req_fire),
      .push_id (winner),
      .pop     (resp_fire),
      .head    (head_id),
      .full    (q_full),
      .empty   (q_empty)
   );

`ifdef CACHE_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_count0   <= '0;
         grant_count1   <= '0;
         conflict_count <= '0;
      end else begin
         if (req_fire && winner == arb_id_t'(0)) grant_count0 <= grant_count0 + 32'd1;
         if (req_fire && winner == arb_id_t'(1)) grant_count1 <= grant_count1 + 32'd1;
         if (req0_val && req1_val)               conflict_count <= conflict_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios plus randomized traffic, all checked every
// cycle against a queue-based reference model and an end-to-end per-requester scoreboard.
module tb_cache_mem_arbiter;
   import cache_arb_pkg::*;

   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         req0_val, req0_rdy, req1_val, req1_rdy;
   mem_req_4B_t  req0_msg, req1_msg, mem_req_msg;
   logic         resp0_val, resp0_rdy, resp1_val, resp1_rdy;
   mem_resp_4B_t resp0_msg, resp1_msg, mem_resp_msg;
   logic         mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;
`ifdef CACHE_ARB_STATS_EN
   logic [31:0]  grant_count0, grant_count1, conflict_count;
`endif

   always #5 clk = ~clk;

   cache_mem_arbiter #(.p_max_outstanding(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .req0_val     (req0_val),
      .req0_rdy     (req0_rdy),
      .req0_msg     (req0_msg),
      .resp0_val    (resp0_val),
      .resp0_rdy    (resp0_rdy),
      .resp0_msg    (resp0_msg),
      .req1_val     (req1_val),
      .req1_rdy     (req1_rdy),
      .req1_msg     (req1_msg),
      .resp1_val    (resp1_val),
      .resp1_rdy    (resp1_rdy),
      .resp1_msg    (resp1_msg),
      .mem_req_val  (mem_req_val),
      .mem_req_rdy  (mem_req_rdy),
      .mem_req_msg  (mem_req_msg),
      .mem_resp_val (mem_resp_val),
      .mem_resp_rdy (mem_resp_rdy),
      .mem_resp_msg (mem_resp_msg)
`ifdef CACHE_ARB_STATS_EN
      ,
      .grant_count0   (grant_count0),
      .grant_count1   (grant_count1),
      .conflict_count (conflict_count)
`endif
   );

   int errors = 0;
   int checks = 0;

   // Stimulus state
   mem_req_4B_t reqq0[$], reqq1[$], memq[$];
   int pct_mrdy, pct_mresp, pct_rdy0, pct_rdy1;
   bit force_resp, force_stray;

   // Reference model state
   int           idq[$];
   int           ptr_m;
   mem_resp_4B_t exp0[$], exp1[$];
   int           grant_log[$], resp_log[$];
   int           stray_cnt;
   logic [31:0]  m_gc0, m_gc1, m_conf;

   // Handshakes observed at the last negedge, consumed by the driver
   logic        f_req0, f_req1, f_mreq, f_mresp;
   mem_req_4B_t f_mreq_msg;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic bit chance(int pct);
      return int'($urandom_range(99)) < pct;
   endfunction

   function automatic mem_req_4B_t mk_req(logic [31:0] addr, int typ);
      mem_req_4B_t r;
      r.msg_type = 3'(typ);
      r.opaque   = 8'($urandom);
      r.addr     = addr;
      r.len      = 2'b00;
      r.data     = $urandom;
      return r;
   endfunction

   // Memory answers each request with data derived from its address.
   function automatic mem_resp_4B_t mk_resp(mem_req_4B_t r);
      mem_resp_4B_t s;
      s.msg_type = r.msg_type;
      s.opaque   = r.opaque;
      s.test     = 2'b00;
      s.len      = r.len;
      s.data     = r.addr ^ 32'hCAFE_0101;
      return s;
   endfunction

   always @(negedge clk) begin
      bit full_m, empty_m, any, mreq_fire, mresp_fire;
      int w, h;
      f_req0     = !reset && req0_val && req0_rdy;
      f_req1     = !reset && req1_val && req1_rdy;
      f_mreq     = !reset && mem_req_val && mem_req_rdy;
      f_mresp    = !reset && mem_resp_val && mem_resp_rdy;
      f_mreq_msg = mem_req_msg;
      if (reset) begin
         check("rst_req0_rdy", req0_rdy, 1'b0);
         check("rst_req1_rdy", req1_rdy, 1'b0);
         check("rst_mem_req_val", mem_req_val, 1'b0);
         check("rst_resp0_val", resp0_val, 1'b0);
         check("rst_resp1_val", resp1_val, 1'b0);
         check("rst_mem_resp_rdy", mem_resp_rdy, 1'b0);
         idq.delete(); exp0.delete(); exp1.delete();
         grant_log.delete(); resp_log.delete();
         ptr_m = 0; m_gc0 = '0; m_gc1 = '0; m_conf = '0;
      end else begin
`ifdef CACHE_ARB_STATS_EN
         check("grant_count0", grant_count0, m_gc0);
         check("grant_count1", grant_count1, m_gc1);
         check("conflict_count", conflict_count, m_conf);
`endif
         full_m  = (idq.size() == DEPTH);
         empty_m = (idq.size() == 0);
         any     = req0_val || req1_val;
         w       = (req0_val && req1_val) ? ptr_m : (req1_val ? 1 : 0);
         if (any) begin
            check("mem_req_val", mem_req_val, !full_m);
            if (!full_m) check("mem_req_msg", mem_req_msg, w ? req1_msg : req0_msg);
            check("winner_rdy", w ? req1_rdy : req0_rdy, mem_req_rdy && !full_m);
            check("loser_rdy", w ? req0_rdy : req1_rdy, 1'b0);
         end else begin
            check("mem_req_val_idle", mem_req_val, 1'b0);
         end
         mresp_fire = 1'b0;
         if (empty_m) begin
            check("resp0_val_empty", resp0_val, 1'b0);
            check("resp1_val_empty", resp1_val, 1'b0);
            check("mem_resp_rdy_empty", mem_resp_rdy, 1'b0);
            if (mem_resp_val) stray_cnt++;
         end else begin
            h = idq[0];
            check("resp_head_val", h ? resp1_val : resp0_val, mem_resp_val);
            check("resp_other_val", h ? resp0_val : resp1_val, 1'b0);
            check("mem_resp_rdy", mem_resp_rdy, h ? resp1_rdy : resp0_rdy);
            if (mem_resp_val) check("resp_head_msg", h ? resp1_msg : resp0_msg, mem_resp_msg);
            mresp_fire = mem_resp_val && (h ? resp1_rdy : resp0_rdy);
         end
         if (req0_val && req0_rdy) grant_log.push_back(0);
         if (req1_val && req1_rdy) grant_log.push_back(1);
         if (resp0_val && resp0_rdy) begin
            resp_log.push_back(0);
            if (exp0.size() == 0) check("resp0_unexpected", resp0_val, 1'b0);
            else                  check("resp0_e2e", resp0_msg, exp0.pop_front());
         end
         if (resp1_val && resp1_rdy) begin
            resp_log.push_back(1);
            if (exp1.size() == 0) check("resp1_unexpected", resp1_val, 1'b0);
            else                  check("resp1_e2e", resp1_msg, exp1.pop_front());
         end
         mreq_fire = any && !full_m && mem_req_rdy;
         if (mresp_fire) void'(idq.pop_front());
         if (mreq_fire) begin
            idq.push_back(w);
            ptr_m = 1 - w;
            if (w == 1) begin exp1.push_back(mk_resp(req1_msg)); m_gc1 = m_gc1 + 32'd1; end
            else        begin exp0.push_back(mk_resp(req0_msg)); m_gc0 = m_gc0 + 32'd1; end
         end
         if (req0_val && req1_val) m_conf = m_conf + 32'd1;
      end
   end

   task automatic step();
      @(posedge clk); #1;
      if (f_req0 && reqq0.size() > 0) void'(reqq0.pop_front());
      if (f_req1 && reqq1.size() > 0) void'(reqq1.pop_front());
      if (f_mresp && memq.size() > 0) void'(memq.pop_front());
      if (f_mreq) memq.push_back(f_mreq_msg);
      req0_val = reqq0.size() > 0;
      if (req0_val) req0_msg = reqq0[0];
      req1_val = reqq1.size() > 0;
      if (req1_val) req1_msg = reqq1[0];
      mem_req_rdy  = chance(pct_mrdy);
      mem_resp_val = (memq.size() > 0 && (chance(pct_mresp) || force_resp)) || force_stray;
      mem_resp_msg = (memq.size() > 0) ? mk_resp(memq[0]) : mk_resp(mk_req($urandom, 1));
      resp0_rdy    = chance(pct_rdy0);
      resp1_rdy    = chance(pct_rdy1);
   endtask

   task automatic wait_chk();
      @(negedge clk); #1;
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Reset with everything asserted, so the gating of every val/rdy output is exercised.
   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      req0_val = 1'b1; req1_val = 1'b1;
      req0_msg = mk_req($urandom, 0); req1_msg = mk_req($urandom, 1);
      mem_req_rdy = 1'b1; mem_resp_val = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
      reqq0.delete(); reqq1.delete(); memq.delete();
      wait_chk();
      check("rstlit_req0_rdy", req0_rdy, 1'b0);
      check("rstlit_req1_rdy", req1_rdy, 1'b0);
      check("rstlit_mem_req_val", mem_req_val, 1'b0);
      check("rstlit_mem_resp_rdy", mem_resp_rdy, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      req0_val = 1'b0; req1_val = 1'b0; mem_req_rdy = 1'b0; mem_resp_val = 1'b0;
      force_resp = 1'b0; force_stray = 1'b0;
      pct_mrdy = 100; pct_mresp = 100; pct_rdy0 = 100; pct_rdy1 = 100;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      req0_val = 1'b0; req1_val = 1'b0; req0_msg = '0; req1_msg = '0;
      resp0_rdy = 1'b0; resp1_rdy = 1'b0; mem_req_rdy = 1'b0;
      mem_resp_val = 1'b0; mem_resp_msg = '0;
      force_resp = 1'b0; force_stray = 1'b0; stray_cnt = 0;
      pct_mrdy = 0; pct_mresp = 0; pct_rdy0 = 0; pct_rdy1 = 0;

      // Single requester: forwarded in the same cycle, response routed back to port 0.
      do_reset();
      reqq0.push_back(mk_req(32'h100, 0));
      step(); wait_chk();
      check("t1_mem_req_val", mem_req_val, 1'b1);
      check("t1_mem_req_addr", mem_req_msg.addr, 32'h100);
      step(); wait_chk();
      check("t1_resp0_val", resp0_val, 1'b1);
      check("t1_resp0_data", resp0_msg.data, 32'hCAFE0001);
      check("t1_resp1_val", resp1_val, 1'b0);
      run(3);

      // Contention: grants and responses alternate starting from port 0.
      do_reset();
      for (int i = 0; i < 2; i++) begin
         reqq0.push_back(mk_req(32'h1000 + i * 4, 0));
         reqq1.push_back(mk_req(32'h2000 + i * 4, 1));
      end
      run(8); wait_chk();
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t2_grant%0d", i), (i < grant_log.size()) ? grant_log[i] : 99, i % 2);
         check($sformatf("t2_route%0d", i), (i < resp_log.size()) ? resp_log[i] : 99, i % 2);
      end

      // Queue full: the fifth request waits until a response has been popped.
      do_reset();
      pct_mresp = 0;
      for (int i = 0; i < 5; i++) reqq0.push_back(mk_req(32'h300 + i * 4, 0));
      run(5); wait_chk();
      check("t3_full_req0_rdy", req0_rdy, 1'b0);
      check("t3_full_mem_req_val", mem_req_val, 1'b0);
      force_resp = 1'b1;
      step(); wait_chk();
      check("t3_pop_mem_resp_rdy", mem_resp_rdy, 1'b1);
      check("t3_pop_cycle_req0_rdy", req0_rdy, 1'b0);
      force_resp = 1'b0;
      step(); wait_chk();
      check("t3_after_pop_req0_rdy", req0_rdy, 1'b1);
      check("t3_after_pop_mem_req_val", mem_req_val, 1'b1);
      pct_mresp = 100;
      run(8);

      // Response backpressure on port 1 holds the queue head.
      do_reset();
      pct_rdy1 = 0;
      reqq1.push_back(mk_req(32'h200, 0));
      run(2); wait_chk();
      check("t4_hold_resp1_val", resp1_val, 1'b1);
      check("t4_hold_mem_resp_rdy", mem_resp_rdy, 1'b0);
      step(); wait_chk();
      check("t4_hold2_mem_resp_rdy", mem_resp_rdy, 1'b0);
      check("t4_hold2_resp1_data", resp1_msg.data, 32'hCAFE0301);
      pct_rdy1 = 100;
      step(); wait_chk();
      check("t4_release_mem_resp_rdy", mem_resp_rdy, 1'b1);
      step(); wait_chk();
      check("t4_popped_resp1_val", resp1_val, 1'b0);

      // Reset with three requests in flight clears the queue and the pointer.
      do_reset();
      pct_mresp = 0;
      for (int i = 0; i < 3; i++) reqq0.push_back(mk_req(32'h400 + i * 4, 0));
      run(4);
      do_reset();
      force_stray = 1'b1;
      reqq0.push_back(mk_req(32'h500, 0));
      reqq1.push_back(mk_req(32'h600, 1));
      step(); wait_chk();
      check("t5_stray_mem_resp_rdy", mem_resp_rdy, 1'b0);
      check("t5_stray_resp0_val", resp0_val, 1'b0);
      check("t5_ptr0_req0_rdy", req0_rdy, 1'b1);
      check("t5_ptr0_req1_rdy", req1_rdy, 1'b0);
      force_stray = 1'b0;
      run(8);

`ifdef CACHE_ARB_STATS_EN
      do_reset();
      reqq0.push_back(mk_req(32'h700, 0));
      reqq0.push_back(mk_req(32'h704, 0));
      reqq1.push_back(mk_req(32'h800, 0));
      run(6);
      reqq0.push_back(mk_req(32'h708, 0));
      run(4);
      reqq1.push_back(mk_req(32'h804, 0));
      run(4); wait_chk();
      check("t6_grant_count0", grant_count0, 32'd3);
      check("t6_grant_count1", grant_count1, 32'd2);
      check("t6_conflict_count", conflict_count, 32'd2);
`endif

      // Randomized traffic with varying load and backpressure, one reset partway.
      do_reset();
      for (int blk = 0; blk < 8; blk++) begin
         int p0, p1;
         if (blk == 4) do_reset();
         p0        = $urandom_range(100);
         p1        = $urandom_range(100);
         pct_mrdy  = 20 + $urandom_range(80);
         pct_mresp = 20 + $urandom_range(80);
         pct_rdy0  = 20 + $urandom_range(80);
         pct_rdy1  = 20 + $urandom_range(80);
         for (int c = 0; c < 400; c++) begin
            if (reqq0.size() < 2 && chance(p0)) reqq0.push_back(mk_req($urandom, $urandom_range(1)));
            if (reqq1.size() < 2 && chance(p1)) reqq1.push_back(mk_req($urandom, $urandom_range(1)));
            step();
         end
      end
      wait_chk();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
